// File: rtl/mem_access_ctrl.sv
// Initiator side of the DataMemory port: load, store and block-copy sequencing
// behind a valid/ready request handshake.
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | waiting for a request, req_ready=1
// S_LOAD    | single read, resp_data captured on exit
// S_STORE   | single write, commits on exit
// S_COPY_RD | read src+idx into the copy buffer
// S_COPY_WR | write buffer to dst+idx, then advance idx
// S_RESP    | one-cycle completion pulse
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] memReadData
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_STORE   = 3'd2,
    S_COPY_RD = 3'd3,
    S_COPY_WR = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr2_q, len_q, idx_q;
  logic [ADDR_W-1:0] idx_inc;
  logic [DATA_W-1:0] wdata_q, buf_q, resp_data_q;
  logic              accept;

  assign accept  = (state == S_IDLE) && req_valid;
  assign idx_inc = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_LOAD:  state_nxt = S_LOAD;
            OP_STORE: state_nxt = S_STORE;
            OP_COPY:  state_nxt = (req_len != '0) ? S_COPY_RD : S_RESP;
            default:  state_nxt = S_RESP;
          endcase
        end
      end
      S_LOAD:    state_nxt = S_RESP;
      S_STORE:   state_nxt = S_RESP;
      S_COPY_RD: state_nxt = S_COPY_WR;
      S_COPY_WR: state_nxt = (idx_inc == len_q) ? S_RESP : S_COPY_RD;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Request fields are frozen at accept; the bus is driven only from these copies.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      addr_q      <= '0;
      addr2_q     <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        addr2_q <= req_addr2;
        len_q   <= req_len;
        wdata_q <= req_wdata;
        idx_q   <= '0;
      end
      if (state == S_LOAD)    resp_data_q <= memReadData;
      if (state == S_COPY_RD) buf_q       <= memReadData;
      if (state == S_COPY_WR) idx_q       <= idx_inc;
    end
  end

  always_comb begin
    req_ready    = 1'b0;
    busy         = 1'b1;
    resp_valid   = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        MemRead    = 1'b1;
        memAddress = addr_q;
      end
      S_STORE: begin
        MemWrite     = 1'b1;
        memAddress   = addr_q;
        memWriteData = wdata_q;
      end
      S_COPY_RD: begin
        MemRead    = 1'b1;
        memAddress = addr_q + idx_q;
      end
      S_COPY_WR: begin
        MemWrite     = 1'b1;
        memAddress   = addr2_q + idx_q;
        memWriteData = buf_q;
      end
      S_RESP:  resp_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural DataMemory attached.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr, req_addr2, req_len, req_wdata;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       busy;
  logic [7:0] memAddress, memWriteData, memReadData;
  logic       MemRead, MemWrite;

  int n_vec = 0;
  int n_err = 0;
  int both_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] rd_log [$];
  logic [7:0] wr_log [$];
  bit         ev_log [$];

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_addr2(req_addr2), .req_len(req_len),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  assign memReadData = MemRead ? mem[memAddress] : 8'h00;

  always @(posedge clk) begin
    if (MemWrite === 1'b1) begin
      mem[memAddress] <= memWriteData;
      wr_log.push_back(memAddress);
      ev_log.push_back(1'b1);
    end
    if (MemRead === 1'b1) begin
      rd_log.push_back(memAddress);
      ev_log.push_back(1'b0);
    end
    if (MemRead === 1'b1 && MemWrite === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, scrambles the inputs after accept, and counts cycles
  // from accept to the resp_valid cycle inclusive.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] a2,
                       input logic [7:0] len, input logic [7:0] wd,
                       output int cyc, output logic [7:0] rd);
    bit done;
    @(negedge clk);
    chk("ready_before_req", req_ready, 1);
    req_op = op; req_addr = a; req_addr2 = a2; req_len = len; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = ~a; req_addr2 = ~a2; req_len = ~len; req_wdata = ~wd; req_op = ~op;
    cyc = 0; rd = 8'h00; done = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (resp_valid === 1'b1) begin
        done = 1;
        rd = resp_data;
      end
    end
    if (!done) chk("resp_timeout", 0, 1);
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    int c; logic [7:0] r;
    issue(2'b01, a, 8'h00, 8'h00, d, c, r);
  endtask

  initial begin
    int cyc, s_rd, s_wr, s_ev, bad, k, w0, resp_at;
    logic [7:0] rd;
    logic [7:0] exp4 [4];
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;

    RST = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    req_addr = 8'h00; req_addr2 = 8'h00; req_len = 8'h00; req_wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_addr", memAddress, 0);
    chk("rst_wdata", memWriteData, 0);
    RST = 1'b0;

    // store then load
    s_wr = wr_log.size();
    issue(2'b01, 8'h00, 8'h00, 8'h00, 8'hC9, cyc, rd);
    chk("store_latency", cyc, 2);
    chk("store_wr_count", wr_log.size() - s_wr, 1);
    chk("store_wr_addr", wr_log[s_wr], 8'h00);
    chk("store_mem", mem[8'h00], 8'hC9);
    s_rd = rd_log.size();
    issue(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, cyc, rd);
    chk("load_latency", cyc, 2);
    chk("load_data", rd, 8'hC9);
    chk("load_rd_count", rd_log.size() - s_rd, 1);

    // reserved op: no access, resp_data kept
    s_rd = rd_log.size(); s_wr = wr_log.size();
    issue(2'b11, 8'h05, 8'h00, 8'h00, 8'h00, cyc, rd);
    chk("rsv_latency", cyc, 1);
    chk("rsv_resp_data", rd, 8'hC9);
    chk("rsv_no_access", (rd_log.size() - s_rd) + (wr_log.size() - s_wr), 0);

    // copy 4 words 0x00 -> 0x10
    for (int i = 0; i < 4; i++) store(i[7:0], exp4[i]);
    s_rd = rd_log.size(); s_wr = wr_log.size(); s_ev = ev_log.size();
    issue(2'b10, 8'h00, 8'h10, 8'd4, 8'h00, cyc, rd);
    chk("copy4_latency", cyc, 9);
    chk("copy4_events", ev_log.size() - s_ev, 8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (s_ev + i < ev_log.size() && ev_log[s_ev + i] != bit'(i % 2)) bad++;
    chk("copy4_alternate", bad, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_log[s_rd + i] !== 8'(i)) bad++;
      if (wr_log[s_wr + i] !== 8'(8'h10 + i)) bad++;
    end
    chk("copy4_addrs", bad, 0);
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 8'(8'h10 + i), 8'h00, 8'h00, 8'h00, cyc, rd);
      chk("copy4_readback", rd, exp4[i]);
    end

    // len=0
    s_rd = rd_log.size(); s_wr = wr_log.size();
    issue(2'b10, 8'h00, 8'h30, 8'd0, 8'h00, cyc, rd);
    chk("len0_latency", cyc, 1);
    chk("len0_no_access", (rd_log.size() - s_rd) + (wr_log.size() - s_wr), 0);

    // wrap-around source
    store(8'hFE, 8'h5A);
    store(8'hFF, 8'h6B);
    s_rd = rd_log.size();
    issue(2'b10, 8'hFE, 8'h40, 8'd3, 8'h00, cyc, rd);
    chk("wrap_latency", cyc, 7);
    chk("wrap_rd0", rd_log[s_rd], 8'hFE);
    chk("wrap_rd1", rd_log[s_rd + 1], 8'hFF);
    chk("wrap_rd2", rd_log[s_rd + 2], 8'h00);
    issue(2'b00, 8'h42, 8'h00, 8'h00, 8'h00, cyc, rd);
    chk("wrap_readback", rd, 8'h11);

    // req_valid held through a copy with a different op
    @(negedge clk);
    s_wr = wr_log.size();
    req_op = 2'b10; req_addr = 8'h00; req_addr2 = 8'h50; req_len = 8'd2; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_op = 2'b01; req_addr = 8'h60; req_wdata = 8'h77;
    bad = 0; resp_at = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (resp_valid === 1'b1) resp_at = i;
    end
    chk("held_busy_ready", bad, 0);
    chk("held_resp_at", resp_at, 5);
    chk("held_copy_writes", wr_log.size() - s_wr, 2);
    @(negedge clk);
    chk("held_idle_ready", req_ready, 1);
    chk("held_idle_busy", busy, 0);
    @(negedge clk);
    chk("held_store_we", MemWrite, 1);
    chk("held_store_addr", memAddress, 8'h60);
    chk("held_store_data", memWriteData, 8'h77);
    req_valid = 1'b0;
    @(negedge clk);
    chk("held_store_resp", resp_valid, 1);
    chk("held_copy_mem51", mem[8'h51], 8'h22);

    // overlapping copy dst = src+1
    store(8'h20, 8'hAA); store(8'h21, 8'h01); store(8'h22, 8'h02); store(8'h23, 8'h03);
    issue(2'b10, 8'h20, 8'h21, 8'd3, 8'h00, cyc, rd);
    for (int i = 1; i <= 3; i++) begin
      issue(2'b00, 8'(8'h20 + i), 8'h00, 8'h00, 8'h00, cyc, rd);
      chk("overlap_readback", rd, 8'hAA);
    end

    // reset during COPY_WR
    @(negedge clk);
    req_op = 2'b10; req_addr = 8'h00; req_addr2 = 8'h70; req_len = 8'd4; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 0;
    while (MemWrite !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rstcopy_reached_wr", MemWrite, 1);
    w0 = wr_log.size();
    RST = 1'b1;
    #1;
    chk("rstcopy_we", MemWrite, 0);
    chk("rstcopy_re", MemRead, 0);
    chk("rstcopy_ready", req_ready, 1);
    chk("rstcopy_busy", busy, 0);
    chk("rstcopy_resp_data", resp_data, 0);
    repeat (2) @(negedge clk);
    RST = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstcopy_no_writes", wr_log.size() - w0, 0);
    chk("rstcopy_idle", busy, 0);

    chk("rw_exclusive", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the DataMemory port. Accepts load, store and block-copy requests from the control path over a valid/ready handshake.
- Drives memAddress, the write-data bus (which connects to DataMemory's regReadDataTwo), MemRead and MemWrite. Samples memReadData.
- Sequences multi-cycle block copies so the datapath never touches memory control directly.
- DataMemory contract: a write commits at posedge clk while MemWrite=1; memReadData is combinational from memAddress while MemRead=1.

Parameters:
- ADDR_W, 8, width of memory address and copy length
- DATA_W, 8, width of a memory word

Ports:
- clk  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request (IDLE only)
- req_op  input  2  00 load, 01 store, 10 copy, 11 reserved
- req_addr  input  ADDR_W  load/store address; copy source base
- req_addr2  input  ADDR_W  copy destination base
- req_len  input  ADDR_W  copy length in words (0..255)
- req_wdata  input  DATA_W  store data
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  DATA_W  load result, held until next load completes
- busy  output  1  high in any state other than IDLE
- memAddress  output  ADDR_W  to DataMemory
- memWriteData  output  DATA_W  to DataMemory regReadDataTwo
- MemRead  output  1  to DataMemory
- MemWrite  output  1  to DataMemory
- memReadData  input  DATA_W  from DataMemory

Behaviour:
- States: IDLE, LOAD, STORE, COPY_RD, COPY_WR, RESP.
- Reset (async, any state): state=IDLE. req_ready=1, resp_valid=0, resp_data=0, busy=0, MemRead=0, MemWrite=0, memAddress=0, memWriteData=0. Internal index, copy buffer and latched request fields clear to 0.
- Reset mid-copy aborts with no further writes. Bytes already written stay written.
- Accept: a request is accepted at a rising edge with state=IDLE and req_valid=1. All req_* fields are latched at that edge and later changes are ignored.
- Next state on accept: op 00 goes to LOAD; op 01 goes to STORE. Op 10 goes to COPY_RD if len!=0, otherwise RESP. Op 11 goes to RESP, with no memory access and resp_data unchanged.
- LOAD (1 cycle): MemRead=1, memAddress=addr. resp_data captures memReadData at the exiting edge. Next state RESP.
- STORE (1 cycle): MemWrite=1, memAddress=addr, memWriteData=wdata. The write commits at the exiting edge. Next state RESP.
- COPY_RD (1 cycle): MemRead=1, memAddress=(src+idx) mod 256. The buffer captures memReadData at the exiting edge. Next state COPY_WR.
- COPY_WR (1 cycle): MemWrite=1, memAddress=(dst+idx) mod 256, memWriteData=buffer. Then idx increments. If the new idx equals len, go to RESP; otherwise go to COPY_RD.
- RESP (1 cycle): resp_valid=1. Next state IDLE.
- Latency, with accept at edge k:
  - load/store: resp_valid high in the cycle after edge k+1.
  - copy of N words: 2N+1 cycles from accept to the resp_valid cycle inclusive.
- Back-to-back requests: the next accept is possible at the edge that leaves RESP+IDLE, i.e. the earliest edge with state=IDLE.
- Outside their active states, MemRead, MemWrite, memAddress and memWriteData are 0. MemRead and MemWrite are never high together.
- Copy direction is always ascending, byte by byte. Overlapping regions with dst>src propagate earlier bytes; this is defined behaviour, not an error.
- Address arithmetic wraps modulo 2^ADDR_W. Example: src=0xFE, len=3 reads 0xFE, 0xFF, 0x00.
- req_valid while busy is ignored, not queued (req_ready=0).

Test Plan:
1. Reset mid-copy: assert RST with state=COPY_WR -> MemWrite=0 immediately (async), state=IDLE, req_ready=1, no further writes after RST deasserts.
2. Store then load:
   - store addr=0x00 data=0xC9 -> MemWrite=1 for exactly one cycle with memAddress=0x00, then a resp_valid pulse.
   - load addr=0x00 -> resp_data=0xC9 in the resp_valid cycle, two cycles after accept.
3. Copy src=0x00 len=4 dst=0x10, memory 0x00..0x03 = 0x11,0x22,0x33,0x44 -> alternating read/write cycles. Loads of 0x10..0x13 return 0x11..0x44. resp_valid occurs 9 cycles after accept, inclusive.
4. Copy edge cases:
   - len=0 -> resp_valid the cycle after accept, MemRead/MemWrite never asserted.
   - src=0xFE len=3 dst=0x40 -> reads 0xFE, 0xFF, 0x00 in order.
5. req_valid held high throughout a copy with a different op -> ignored until IDLE, then accepted on the first IDLE edge. req_ready=0 and busy=1 throughout the copy.
6. Overlap: memory 0x20=0xAA, src=0x20 dst=0x21 len=3 -> 0x21..0x23 all read back 0xAA.
